cpu_rdata_fifo: RTL and testbench

CPU_RDATA_FIFO -- requirements
Module: cpu_rdata_fifo

---
 rtl/bram_pkg.sv | 17 +
 rtl/rd_credit_cnt.sv | 67 ++++++
 rtl/cpu_rdata_fifo.sv | 97 +++++++++
 tb/tb_cpu_rdata_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// ----------------------------------------------------------------------------
// bram_pkg
// Shared constants for the BRAM read path: controller latency, data width
// and the depth of the CPU-side read-data FIFO, plus a small width helper.
// ----------------------------------------------------------------------------
package bram_pkg;

    localparam int BRAM_LATENCY     = 10;
    localparam int BRAM_DW          = 32;
    localparam int RDATA_FIFO_DEPTH = 16;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : bram_pkg

// File: rtl/rd_credit_cnt.sv
// ----------------------------------------------------------------------------
// rd_credit_cnt
// Tracks reads issued to the BRAM controller whose data has not yet come back,
// derives the issue credit from that plus the FIFO occupancy, and holds the
// sticky overflow flag.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   req_issue     : arbiter issued one read this cycle
//   in_valid      : read data returned this cycle
//   drop          : FIFO discarded returning data (full, no pop)
//   count         : current FIFO occupancy
//   outstanding   : reads in flight (0..DEPTH)
//   credit_ok     : (outstanding + count) < DEPTH
//   overflow      : sticky error, cleared only by rst
// ----------------------------------------------------------------------------
module rd_credit_cnt
    import bram_pkg::*;
#(
    parameter  int DEPTH = RDATA_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_issue,
    input  logic          in_valid,
    input  logic          drop,
    input  logic [AW:0]   count,
    output logic [AW:0]   outstanding,
    output logic          credit_ok,
    output logic          overflow
);

    localparam logic [AW:0]   C_OUT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] C_DEPTH_W = (AW+2)'(DEPTH);

    logic [AW:0]   r_outstanding;
    logic          r_overflow;
    logic [AW+1:0] w_sum;

    // One extra bit so outstanding + count never wraps.
    assign w_sum     = {1'b0, r_outstanding} + {1'b0, count};
    assign credit_ok = (w_sum < C_DEPTH_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_overflow    <= 1'b0;
        end else begin
            // Simultaneous issue and return cancel out.
            if (req_issue && !in_valid) begin
                if (r_outstanding != C_OUT_MAX)
                    r_outstanding <= r_outstanding + 1'b1;
            end else if (in_valid && !req_issue) begin
                // Unsolicited data (e.g. write echo) must not wrap below zero.
                if (r_outstanding != '0)
                    r_outstanding <= r_outstanding - 1'b1;
            end
            if ((req_issue && !credit_ok) || drop)
                r_overflow <= 1'b1;
        end
    end

    assign outstanding = r_outstanding;
    assign overflow    = r_overflow;

endmodule : rd_credit_cnt

// File: rtl/cpu_rdata_fifo.sv
// ----------------------------------------------------------------------------
// cpu_rdata_fifo
// First-word-fall-through FIFO between the BRAM controller read-data return
// and the CPU, with credit tracking so the arbiter never has more reads in
// flight than the FIFO can absorb.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   req_issue     : arbiter issued one BRAM read this cycle
//   credit_ok     : arbiter may issue another read
//   in_valid/data : read data from BRAM controller
//   out_valid/data: FIFO head (zero-latency, FWFT)
//   out_ready     : CPU pops head this cycle
//   count         : stored entries 0..DEPTH
//   outstanding   : reads issued but not yet returned
//   overflow      : sticky error flag
// ----------------------------------------------------------------------------
module cpu_rdata_fifo
    import bram_pkg::*;
#(
    parameter  int DW    = BRAM_DW,
    parameter  int DEPTH = RDATA_FIFO_DEPTH,   // power of two, >= 2
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_issue,
    output logic          credit_ok,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic [AW:0]   outstanding,
    output logic          overflow
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_pop  = out_ready & (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = in_valid & ((r_count < C_DEPTH) | w_pop);
    assign w_drop = in_valid & ~w_push;

    // Storage is deliberately not reset; pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    rd_credit_cnt #(
        .DEPTH (DEPTH)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .req_issue   (req_issue),
        .in_valid    (in_valid),
        .drop        (w_drop),
        .count       (r_count),
        .outstanding (outstanding),
        .credit_ok   (credit_ok),
        .overflow    (overflow)
    );

endmodule : cpu_rdata_fifo

// File: tb/tb_cpu_rdata_fifo.sv
// ----------------------------------------------------------------------------
// tb_cpu_rdata_fifo
// Self-checking bench for cpu_rdata_fifo: a vector table for the basic
// read/return/pop flow, hand-written corner sequences, and randomized traffic
// compared against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_cpu_rdata_fifo;
    import bram_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_issue;
    logic          credit_ok;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW:0]   count;
    logic [AW:0]   outstanding;
    logic          overflow;

    always #5 clk = ~clk;

    cpu_rdata_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_issue   (req_issue),
        .credit_ok   (credit_ok),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .outstanding (outstanding),
        .overflow    (overflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: data queue, in-flight read count, sticky error.
    logic [DW-1:0] m_q [$];
    int            m_out = 0;
    bit            m_ovf = 1'b0;

    typedef struct {
        bit            ri;
        bit            iv;
        logic [DW-1:0] id;
        bit            ordy;
        int            e_cnt;
        int            e_out;
        bit            e_ov;
        logic [DW-1:0] e_dat;
        bit            e_cr;
        bit            e_ovf;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"},       64'(count),       64'(m_q.size()));
        chk({tag, ".outstanding"}, 64'(outstanding), 64'(m_out));
        chk({tag, ".out_valid"},   64'(out_valid),   64'(m_q.size() != 0));
        chk({tag, ".credit_ok"},   64'(credit_ok),   64'((m_out + m_q.size()) < DEPTH));
        chk({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
        if (m_q.size() != 0)
            chk({tag, ".out_data"}, 64'(out_data), 64'(m_q[0]));
    endtask

    // Behaviour at one clock edge, straight from the block's rules.
    task automatic model_edge(input bit ri, input bit iv, input logic [DW-1:0] id, input bit ordy);
        bit pop, push, credit;
        credit = (m_out + m_q.size()) < DEPTH;
        pop    = ordy && (m_q.size() != 0);
        push   = iv && ((m_q.size() < DEPTH) || pop);
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(id);
        if (iv && !push)     m_ovf = 1'b1;
        if (ri && !credit)   m_ovf = 1'b1;
        if (ri && !iv)       m_out = (m_out < DEPTH) ? m_out + 1 : DEPTH;
        else if (iv && !ri)  m_out = (m_out > 0) ? m_out - 1 : 0;
    endtask

    // Called at a negedge: drive, clock once, compare at the next negedge.
    task automatic step(input bit ri, input bit iv, input logic [DW-1:0] id, input bit ordy);
        req_issue = ri;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        model_edge(ri, iv, id, ordy);
        @(negedge clk);
        check_model("step");
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        req_issue = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_q.delete();
        m_out = 0;
        m_ovf = 1'b0;
        chk("rst.out_valid",   64'(out_valid),   64'(0));
        chk("rst.credit_ok",   64'(credit_ok),   64'(1));
        chk("rst.count",       64'(count),       64'(0));
        chk("rst.outstanding", 64'(outstanding), 64'(0));
        chk("rst.overflow",    64'(overflow),    64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        req_issue = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Vector table: 3 issues, 10 cycles of latency, returns popped
        // back-to-back, empty pop, unsolicited push, issue+return together.
        tbl[0] = '{1, 0, 32'h0,  0, 0, 1, 0, 32'h0,  1, 0};
        tbl[1] = '{1, 0, 32'h0,  0, 0, 2, 0, 32'h0,  1, 0};
        tbl[2] = '{1, 0, 32'h0,  0, 0, 3, 0, 32'h0,  1, 0};
        for (int i = 3; i < 10; i++)
            tbl[i] = '{0, 0, 32'h0, 0, 0, 3, 0, 32'h0, 1, 0};
        tbl[10] = '{0, 1, 32'hA1, 1, 1, 2, 1, 32'hA1, 1, 0};
        tbl[11] = '{0, 1, 32'hB2, 1, 1, 1, 1, 32'hB2, 1, 0};
        tbl[12] = '{0, 1, 32'hC3, 1, 1, 0, 1, 32'hC3, 1, 0};
        tbl[13] = '{0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0};
        tbl[14] = '{0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0};
        tbl[15] = '{0, 1, 32'h5A, 0, 1, 0, 1, 32'h5A, 1, 0};
        tbl[16] = '{1, 1, 32'h66, 0, 2, 0, 1, 32'h5A, 1, 0};
        tbl[17] = '{0, 0, 32'h0,  1, 1, 0, 1, 32'h66, 1, 0};
        tbl[18] = '{0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0};

        do_reset();

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].ri, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("vec%0d.count", i),       64'(count),       64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.outstanding", i), 64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("vec%0d.out_valid", i),   64'(out_valid),   64'(tbl[i].e_ov));
            chk($sformatf("vec%0d.credit_ok", i),   64'(credit_ok),   64'(tbl[i].e_cr));
            chk($sformatf("vec%0d.overflow", i),    64'(overflow),    64'(tbl[i].e_ovf));
            if (tbl[i].e_ov)
                chk($sformatf("vec%0d.out_data", i), 64'(out_data), 64'(tbl[i].e_dat));
        end

        // 16 issues fill the credit; 16 returns fill the FIFO; one pop frees credit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, '0, 0);
            if (i == 14) chk("fill.credit15", 64'(credit_ok), 64'(1));
        end
        chk("fill.credit16", 64'(credit_ok),   64'(0));
        chk("fill.out16",    64'(outstanding), 64'(16));
        for (int i = 0; i < 16; i++)
            step(0, 1, 32'h100 + 32'(i), 0);
        chk("fill.count16", 64'(count),       64'(16));
        chk("fill.credit0", 64'(credit_ok),   64'(0));
        chk("fill.out0",    64'(outstanding), 64'(0));
        step(0, 0, '0, 1);
        chk("pop.credit", 64'(credit_ok), 64'(1));
        chk("pop.head",   64'(out_data),  64'(32'h101));

        // Full with push+pop keeps count; full with push only drops and flags.
        step(0, 1, 32'hEE, 0);
        chk("full.count", 64'(count), 64'(16));
        step(0, 1, 32'hF0, 1);
        chk("fullpp.count", 64'(count),    64'(16));
        chk("fullpp.head",  64'(out_data), 64'(32'h102));
        chk("fullpp.ovf",   64'(overflow), 64'(0));
        step(0, 1, 32'hF1, 0);
        chk("drop.count", 64'(count),    64'(16));
        chk("drop.ovf",   64'(overflow), 64'(1));
        step(0, 0, '0, 0);
        chk("drop.sticky", 64'(overflow), 64'(1));
        for (int i = 0; i < 17; i++)
            step(0, 0, '0, 1);
        chk("drain.count",  64'(count),    64'(0));
        chk("drain.sticky", 64'(overflow), 64'(1));

        // Issue without credit: overflow and saturating increment.
        do_reset();
        step(0, 1, 32'h11, 0);
        step(0, 1, 32'h22, 0);
        for (int i = 0; i < 14; i++)
            step(1, 0, '0, 0);
        chk("nocr.credit", 64'(credit_ok), 64'(0));
        step(1, 0, '0, 0);
        chk("nocr.ovf",   64'(overflow),    64'(1));
        chk("nocr.out15", 64'(outstanding), 64'(15));
        step(1, 0, '0, 0);
        chk("nocr.out16", 64'(outstanding), 64'(16));
        step(1, 0, '0, 0);
        chk("nocr.sat16", 64'(outstanding), 64'(16));

        // Reset mid-operation with count=5, outstanding=4.
        do_reset();
        for (int i = 0; i < 5; i++)
            step(0, 1, 32'h200 + 32'(i), 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, '0, 0);
        chk("mid.count", 64'(count),       64'(5));
        chk("mid.out",   64'(outstanding), 64'(4));
        do_reset();
        for (int i = 0; i < 24; i++)
            step(0, 1, 32'h300 + 32'(i), (i > 1));
        for (int i = 0; i < 3; i++)
            step(0, 0, '0, 1);
        chk("wrap.empty", 64'(out_valid), 64'(0));

        // Randomized traffic, balanced then push-heavy, against the model.
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1);
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cpu_rdata_fifo
